jr31_pred_tracker: RTL and testbench
====================================

# jr31_pred_tracker

Tracks every in-flight JR $31 whose target was predicted by the return address stack at dispatch, holding the predicted address until the instruction's real target is broadcast on the CDB. On a match the entry retires silently. On a mismatch it squashes that entry and all younger ones, and raises a held flush request carrying the correct PC to fetch. It sits directly downstream of the RAS pop port and alongside the dispatch unit.

## Interface
- DEPTH, 4, max outstanding predicted JR $31 (power of two)
- ADDR_W, 32, PC width
- TAG_W, 5, ROB tag width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- du_jr31_alloc  in  1  dispatch of a predicted JR $31 this cycle
- du_jr31_tag  in  TAG_W  ROB tag of that JR $31
- du_jr31_pred_addr  in  ADDR_W  predicted target (RAS pop output)
- tracker_full  out  1  dispatch must not assert du_jr31_alloc
- cdb_valid  in  1  CDB broadcast valid
- cdb_is_jr31  in  1  broadcast is a resolved JR $31
- cdb_tag  in  TAG_W  ROB tag on CDB
- cdb_jr_addr  in  ADDR_W  actual target ($31 value)
- rob_flush_all  in  1  external flush; empties tracker
- flush_valid  out  1  misprediction flush request
- flush_pc  out  ADDR_W  correct target
- flush_tag  out  TAG_W  tag of mispredicted JR $31
- flush_ack  in  1  fetch has taken the flush

## Operation
- Circular buffer of DEPTH entries {valid, resolved, tag, pred_addr}. Head/tail pointers are clog2(DEPTH)+1 bits. Empty: pointers equal. Full: index equal, MSB differs.
- Alloc: writes the entry at tail, sets valid, increments tail. Ignored when tracker_full (the bench flags it as an error).
- Resolve, when cdb_valid & cdb_is_jr31: tag CAM over valid, unresolved entries.
  - No hit (already squashed): ignored.
  - Hit with cdb_jr_addr == pred_addr: sets resolved.
  - Hit with a mismatch: tail <= hit index (that entry and all younger entries squashed), flush_pc <= cdb_jr_addr, flush_tag <= cdb_tag, FSM -> FLUSH.
- Retire: if head entry is valid & resolved, clear it and advance head. At most one retire per cycle.
- FSM states:
  - NORMAL -> FLUSH on mismatch.
  - FLUSH -> NORMAL on flush_ack.
  - flush_valid = (state == FLUSH), held stable until acked.
  - tracker_full is also forced high in FLUSH.
  - CDB resolves are still processed in FLUSH. A second mismatch in FLUSH is for an older entry: it overwrites flush_pc/flush_tag and moves tail again.
- rob_flush_all: head = tail = 0, all valid cleared, FSM -> NORMAL, flush_valid drops. It has priority over every other event.
- Simultaneous events in one cycle:
  - alloc + mismatch: the alloc is dropped, because it is younger.
  - alloc + match/retire: both take effect.
  - retire + mismatch on a different entry: both take effect.
  - mismatch on the head entry itself: the tracker becomes empty.

## Timing
- Reset values: tracker_full 0, flush_valid 0, flush_pc 0, flush_tag 0, FSM NORMAL, pointers 0.
- tracker_full is combinational from registered state: (full | state == FLUSH).
- Alloc visible to the CAM on the cycle after the alloc edge.
- Mismatch on CDB at edge N: flush_valid high from N+1 until the edge where flush_ack is sampled high. It is low the cycle after that edge.
- A match sets resolved at edge N. The entry retires at edge N+1 if it is at head.
- A reset assertion mid-flush clears flush_valid immediately (asynchronous).

## Configuration
- JR31_TRACK_STATS_EN defined:
  - Adds outputs stat_pred_cnt and stat_mispred_cnt (16-bit each, saturating at 0xFFFF).
  - stat_pred_cnt counts accepted allocs; stat_mispred_cnt counts mismatches.
  - Both are cleared by reset, not by rob_flush_all.
- Not defined: ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package jr31_track_pkg holds: DEPTH/ADDR_W/TAG_W defaults, the entry struct typedef, and the FSM state enum {NORMAL, FLUSH}.
- One sub-module, jr31_tag_cam: DEPTH-way tag compare. It returns a hit flag and the hit index, qualified by valid & ~resolved.

## Test plan
- Alloc tags 3,4 with pred 0x100,0x200; CDB tag 3 addr 0x100 then tag 4 addr 0x200 -> no flush_valid, tracker empty two cycles after the last resolve.
- Alloc tags 1,2,5,6 -> tracker_full=1; fifth alloc ignored; resolve tag 1 correct -> tracker_full drops after retire.
- Alloc tags 1,2,5; CDB tag 2 addr 0x344 vs pred 0x300 -> flush_valid, flush_pc=0x344, flush_tag=2; a later CDB tag 5 is ignored; flush_ack -> NORMAL.
- Mismatch while du_jr31_alloc=1 same cycle -> alloc dropped; tail equals the mismatched index.
- rob_flush_all during FLUSH with 3 entries -> flush_valid=0 and tracker empty next cycle; reset low mid-operation -> all outputs 0 asynchronously.
- With JR31_TRACK_STATS_EN: 4 allocs, 1 mismatch -> stat_pred_cnt=4, stat_mispred_cnt=1.

Source files
------------

// File: rtl/jr31_pred_tracker_pkg.sv
// Shared types for the JR $31 return-prediction tracker: default widths,
// the tracker entry layout and the flush FSM states.
package jr31_track_pkg;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int TAG_W  = 5;

    typedef struct packed {
        logic              valid;
        logic              resolved;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] pred_addr;
    } entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } state_t;
endpackage

// File: rtl/jr31_pred_tracker_if.sv
// Dispatch, CDB and fetch-flush signals seen by the JR $31 prediction tracker.
interface jr31_pred_tracker_if import jr31_track_pkg::*; ();
    logic              du_jr31_alloc;
    logic [TAG_W-1:0]  du_jr31_tag;
    logic [ADDR_W-1:0] du_jr31_pred_addr;
    logic              tracker_full;
    logic              cdb_valid;
    logic              cdb_is_jr31;
    logic [TAG_W-1:0]  cdb_tag;
    logic [ADDR_W-1:0] cdb_jr_addr;
    logic              rob_flush_all;
    logic              flush_valid;
    logic [ADDR_W-1:0] flush_pc;
    logic [TAG_W-1:0]  flush_tag;
    logic              flush_ack;

    modport master (
        output du_jr31_alloc, du_jr31_tag, du_jr31_pred_addr,
        output cdb_valid, cdb_is_jr31, cdb_tag, cdb_jr_addr,
        output rob_flush_all, flush_ack,
        input  tracker_full, flush_valid, flush_pc, flush_tag
    );

    modport slave (
        input  du_jr31_alloc, du_jr31_tag, du_jr31_pred_addr,
        input  cdb_valid, cdb_is_jr31, cdb_tag, cdb_jr_addr,
        input  rob_flush_all, flush_ack,
        output tracker_full, flush_valid, flush_pc, flush_tag
    );
endinterface

// File: rtl/jr31_tag_cam.sv
// Tag CAM over tracker entries; only valid, still-unresolved entries can hit.
module jr31_tag_cam import jr31_track_pkg::*; #(
    parameter int DEPTH = jr31_track_pkg::DEPTH
) (
    input  entry_t [DEPTH-1:0]         ent,
    input  logic [TAG_W-1:0]           tag,
    output logic                       hit,
    output logic [$clog2(DEPTH)-1:0]   hit_idx
);
    localparam int IW = $clog2(DEPTH);

    // ROB tags are unique among in-flight entries, so the first hit is the only hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && ent[i].valid && !ent[i].resolved && ent[i].tag == tag) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end
endmodule

// File: rtl/jr31_pred_tracker.sv
// Tracks RAS-predicted JR $31 instructions until their CDB resolve and raises a
// held flush on misprediction. Optional counters: `define JR31_TRACK_STATS_EN.
module jr31_pred_tracker import jr31_track_pkg::*; #(
    parameter int DEPTH = jr31_track_pkg::DEPTH
) (
    input  logic                clk,
    input  logic                reset,
`ifdef JR31_TRACK_STATS_EN
    output logic [15:0]         stat_pred_cnt,
    output logic [15:0]         stat_mispred_cnt,
`endif
    jr31_pred_tracker_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    entry_t [DEPTH-1:0] ent_q;
    logic [PW-1:0]      head_q, tail_q;
    logic [ADDR_W-1:0]  flush_pc_q;
    logic [TAG_W-1:0]   flush_tag_q;
    state_t             state_q, state_d;

    logic [IW-1:0]      head_idx, tail_idx, hit_idx, hit_off, off;
    logic               hit, full, retire, resolve, match, mism, alloc_ok;
    logic [DEPTH-1:0]   squash;

    jr31_tag_cam #(.DEPTH(DEPTH)) u_cam (
        .ent     (ent_q),
        .tag     (bus.cdb_tag),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
    assign retire   = ent_q[head_idx].valid && ent_q[head_idx].resolved;
    assign resolve  = !bus.rob_flush_all && bus.cdb_valid && bus.cdb_is_jr31 && hit;
    assign match    = resolve && (bus.cdb_jr_addr == ent_q[hit_idx].pred_addr);
    assign mism     = resolve && !match;
    assign alloc_ok = !bus.rob_flush_all && bus.du_jr31_alloc && !bus.tracker_full && !mism;
    // Age of the mispredicted entry relative to head; everything at or beyond it is younger.
    assign hit_off  = hit_idx - head_idx;

    assign bus.tracker_full = full || (state_q == FLUSH);
    assign bus.flush_valid  = (state_q == FLUSH);
    assign bus.flush_pc     = flush_pc_q;
    assign bus.flush_tag    = flush_tag_q;

    always_comb begin
        squash = '0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off       = IW'(i) - head_idx;
            squash[i] = mism && (off >= hit_off);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            flush_pc_q  <= '0;
            flush_tag_q <= '0;
        end else if (bus.rob_flush_all) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
        end else begin
            if (retire) begin
                ent_q[head_idx].valid <= 1'b0;
                head_q                <= head_q + PW'(1);
            end
            if (match) ent_q[hit_idx].resolved <= 1'b1;
            if (mism) begin
                for (int i = 0; i < DEPTH; i++)
                    if (squash[i]) ent_q[i].valid <= 1'b0;
                tail_q      <= head_q + {1'b0, hit_off};
                flush_pc_q  <= bus.cdb_jr_addr;
                flush_tag_q <= bus.cdb_tag;
            end else if (alloc_ok) begin
                ent_q[tail_idx] <= '{valid: 1'b1, resolved: 1'b0,
                                     tag: bus.du_jr31_tag, pred_addr: bus.du_jr31_pred_addr};
                tail_q          <= tail_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= NORMAL;
        else        state_q <= state_d;
    end

    // A fresh mismatch wins over an ack in the same cycle: the new target must be fetched.
    always_comb begin
        state_d = state_q;
        if (bus.rob_flush_all)                   state_d = NORMAL;
        else if (mism)                           state_d = FLUSH;
        else if (state_q == FLUSH && bus.flush_ack) state_d = NORMAL;
    end

`ifdef JR31_TRACK_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pred_cnt    <= '0;
            stat_mispred_cnt <= '0;
        end else begin
            if (alloc_ok) stat_pred_cnt    <= sat_inc(stat_pred_cnt);
            if (mism)     stat_mispred_cnt <= sat_inc(stat_mispred_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_jr31_pred_tracker.sv
// Directed bench for jr31_pred_tracker; stats checks apply when JR31_TRACK_STATS_EN is defined.
module tb_jr31_pred_tracker;
    import jr31_track_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    jr31_pred_tracker_if bus();
`ifdef JR31_TRACK_STATS_EN
    logic [15:0] stat_pred_cnt, stat_mispred_cnt;
`endif

    jr31_pred_tracker dut (
        .clk              (clk),
        .reset            (reset),
`ifdef JR31_TRACK_STATS_EN
        .stat_pred_cnt    (stat_pred_cnt),
        .stat_mispred_cnt (stat_mispred_cnt),
`endif
        .bus              (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.du_jr31_alloc     = 1'b0;
        bus.du_jr31_tag       = '0;
        bus.du_jr31_pred_addr = '0;
        bus.cdb_valid         = 1'b0;
        bus.cdb_is_jr31       = 1'b0;
        bus.cdb_tag           = '0;
        bus.cdb_jr_addr       = '0;
        bus.rob_flush_all     = 1'b0;
        bus.flush_ack         = 1'b0;
    endtask

    task automatic do_alloc(input logic [TAG_W-1:0] tag, input logic [ADDR_W-1:0] addr);
        bus.du_jr31_alloc     = 1'b1;
        bus.du_jr31_tag       = tag;
        bus.du_jr31_pred_addr = addr;
        step();
        bus.du_jr31_alloc     = 1'b0;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [ADDR_W-1:0] addr);
        bus.cdb_valid   = 1'b1;
        bus.cdb_is_jr31 = 1'b1;
        bus.cdb_tag     = tag;
        bus.cdb_jr_addr = addr;
    endtask

    task automatic do_cdb(input logic [TAG_W-1:0] tag, input logic [ADDR_W-1:0] addr);
        set_cdb(tag, addr);
        step();
        bus.cdb_valid   = 1'b0;
        bus.cdb_is_jr31 = 1'b0;
    endtask

    initial begin
        clear_in();
        reset = 1'b0;
        repeat (2) step();
        chk("rst_full",  bus.tracker_full, 0);
        chk("rst_fv",    bus.flush_valid,  0);
        chk("rst_pc",    bus.flush_pc,     0);
        chk("rst_tag",   bus.flush_tag,    0);
        chk("rst_head",  dut.head_q,       0);
        chk("rst_tail",  dut.tail_q,       0);
        reset = 1'b1;
        step();

        // Two correct predictions retire without a flush
        do_alloc(5'd3, 32'h100);
        do_alloc(5'd4, 32'h200);
        do_cdb(5'd3, 32'h100);
        chk("t1_fv_a", bus.flush_valid, 0);
        do_cdb(5'd4, 32'h200);
        chk("t1_fv_b", bus.flush_valid, 0);
        step();
        chk("t1_head", dut.head_q, 2);
        chk("t1_tail", dut.tail_q, 2);

        // Fill to full, drop a fifth alloc, retire one to free a slot
        do_alloc(5'd1, 32'h110);
        do_alloc(5'd2, 32'h120);
        do_alloc(5'd5, 32'h150);
        do_alloc(5'd6, 32'h160);
        chk("t2_full", bus.tracker_full, 1);
        do_alloc(5'd7, 32'h170);
        chk("t2_tail_drop", dut.tail_q, 6);
        do_cdb(5'd1, 32'h110);
        chk("t2_full_res", bus.tracker_full, 1);
        step();
        chk("t2_full_ret", bus.tracker_full, 0);
        bus.rob_flush_all = 1'b1;
        step();
        bus.rob_flush_all = 1'b0;
        chk("t2_fa_tail", dut.tail_q, 0);

        // Mismatch on the middle entry squashes it and the younger one
        do_alloc(5'd1, 32'h100);
        do_alloc(5'd2, 32'h300);
        do_alloc(5'd5, 32'h500);
        do_cdb(5'd2, 32'h344);
        chk("t3_fv",   bus.flush_valid,  1);
        chk("t3_pc",   bus.flush_pc,     32'h344);
        chk("t3_tag",  bus.flush_tag,    2);
        chk("t3_tail", dut.tail_q,       1);
        chk("t3_full", bus.tracker_full, 1);
        do_cdb(5'd5, 32'h999);
        chk("t3_ign_pc",   bus.flush_pc, 32'h344);
        chk("t3_ign_tail", dut.tail_q,   1);
        chk("t3_hold",     bus.flush_valid, 1);
        bus.flush_ack = 1'b1;
        step();
        bus.flush_ack = 1'b0;
        chk("t3_ack_fv",   bus.flush_valid,  0);
        chk("t3_ack_full", bus.tracker_full, 0);
        do_cdb(5'd1, 32'h100);
        step();
        chk("t3_head", dut.head_q, 1);
        chk("t3_drain", dut.tail_q, 1);

        // Mismatch with a same-cycle alloc: the alloc is dropped
        do_alloc(5'd8, 32'h800);
        do_alloc(5'd9, 32'h900);
        set_cdb(5'd9, 32'h904);
        bus.du_jr31_alloc     = 1'b1;
        bus.du_jr31_tag       = 5'd10;
        bus.du_jr31_pred_addr = 32'hA00;
        step();
        clear_in();
        chk("t4_tail",   dut.tail_q,          2);
        chk("t4_nowr",   dut.ent_q[3].valid,  0);
        chk("t4_tag",    bus.flush_tag,       9);
        chk("t4_pc",     bus.flush_pc,        32'h904);
        bus.flush_ack = 1'b1;
        step();
        bus.flush_ack = 1'b0;
        // Mismatch on the head entry empties the tracker
        do_cdb(5'd8, 32'h888);
        chk("t4_head_h", dut.head_q, 1);
        chk("t4_head_t", dut.tail_q, 1);
        chk("t4_head_pc", bus.flush_pc, 32'h888);
        bus.flush_ack = 1'b1;
        step();
        bus.flush_ack = 1'b0;

        // rob_flush_all during FLUSH with three live entries
        do_alloc(5'd11, 32'hB00);
        do_alloc(5'd12, 32'hC00);
        do_alloc(5'd13, 32'hD00);
        do_alloc(5'd14, 32'hE00);
        chk("t5_full", bus.tracker_full, 1);
        do_cdb(5'd14, 32'hE04);
        chk("t5_tail", dut.tail_q, 4);
        chk("t5_fv",   bus.flush_valid, 1);
        bus.rob_flush_all = 1'b1;
        step();
        bus.rob_flush_all = 1'b0;
        chk("t5_fa_fv",   bus.flush_valid,  0);
        chk("t5_fa_head", dut.head_q,       0);
        chk("t5_fa_tail", dut.tail_q,       0);
        chk("t5_fa_full", bus.tracker_full, 0);

        // Asynchronous reset in the middle of a flush
        do_alloc(5'd20, 32'h2000);
        do_cdb(5'd20, 32'h2468);
        chk("t6_fv_pre", bus.flush_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_fv",   bus.flush_valid,  0);
        chk("t6_pc",   bus.flush_pc,     0);
        chk("t6_tag",  bus.flush_tag,    0);
        chk("t6_full", bus.tracker_full, 0);
        step();
        reset = 1'b1;
        step();

        // Four allocs then one mismatch
        do_alloc(5'd1, 32'h10);
        do_alloc(5'd2, 32'h20);
        do_alloc(5'd3, 32'h30);
        do_alloc(5'd4, 32'h40);
        do_cdb(5'd2, 32'h99);
        chk("t7_fv",  bus.flush_valid, 1);
        chk("t7_tag", bus.flush_tag,   2);
`ifdef JR31_TRACK_STATS_EN
        chk("t7_pred_cnt",    stat_pred_cnt,    4);
        chk("t7_mispred_cnt", stat_mispred_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
